// File: rtl/store_buf_pkg.sv
// Shared types and constants for the posted-store buffer (mem_store_buffer, sb_fifo).
package store_buf_pkg;

  localparam int unsigned WORD_OFFSET_BITS = 2;
  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned SB_ADDR_W        = 32;
  localparam int unsigned SB_DATA_W        = 32;
  localparam int unsigned SB_MASK_W        = SB_DATA_W / 8;
  localparam int unsigned SB_WORD_W        = SB_ADDR_W - WORD_OFFSET_BITS;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] wdata;
    logic [SB_MASK_W-1:0] wmask;
  } store_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sb_state_t;

  // Word address (byte offset stripped) used for the memory port and load compare.
  function automatic logic [SB_WORD_W-1:0] word_of(input logic [SB_ADDR_W-1:0] a);
    return a[SB_ADDR_W-1:WORD_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular buffer of store entries with per-slot valid bits for address compare.
module sb_fifo
  import store_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  store_entry_t                  push_data,
  input  logic                          pop,
  output store_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0]              valid,
  output store_entry_t [DEPTH-1:0]      entries
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  store_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;

  // Payload storage carries no reset; occupancy is tracked by valid/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        valid[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign entries = mem;

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-store queue draining in order to the data-memory port.
// Optional load-conflict detection is enabled by defining STORE_FWD_EN.
module mem_store_buffer
  import store_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = SB_ADDR_W,
  parameter int unsigned DATA_W = SB_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_W-1:0]            st_addr,
  input  logic [DATA_W-1:0]            st_wdata,
  input  logic [DATA_W/8-1:0]          st_wmask,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_byte_enable,
  input  logic                         mem_resp,
`ifdef STORE_FWD_EN
  input  logic                         ld_valid,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         ld_conflict,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drained
);

  sb_state_t                state;
  store_entry_t             push_data;
  store_entry_t             head;
  store_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]         fifo_valid;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push_c;
  logic                     pop_c;
  logic                     head_live_c;

  assign push_data = '{addr:  SB_ADDR_W'(st_addr),
                       wdata: SB_DATA_W'(st_wdata),
                       wmask: SB_MASK_W'(st_wmask)};

  assign st_ready    = !fifo_full;
  assign push_c      = st_valid && st_ready;
  assign head_live_c = !fifo_empty && (head.wmask != '0);
  // Zero-mask heads are dropped from IDLE; real writes pop on their response.
  assign pop_c       = ((state == IDLE) && !fifo_empty && (head.wmask == '0)) ||
                       ((state == WRITE) && mem_resp);

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_data),
    .pop       (pop_c),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .valid     (fifo_valid),
    .entries   (fifo_entries)
  );

  // Memory-port FSM; outputs are loaded on IDLE->WRITE and held until mem_resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (head_live_c) begin
            state           <= WRITE;
            mem_write       <= 1'b1;
            mem_address     <= ADDR_W'({word_of(head.addr), WORD_OFFSET_BITS'(0)});
            mem_wdata       <= DATA_W'(head.wdata);
            mem_byte_enable <= (DATA_W/8)'(head.wmask);
          end
        end
        WRITE: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign drained = fifo_empty && (state == IDLE);

`ifdef STORE_FWD_EN
  logic [SB_WORD_W-1:0] ld_word;
  assign ld_word = word_of(SB_ADDR_W'(ld_addr));

  // Any occupied entry, including the one in flight, to the same word blocks the load.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ld_valid && fifo_valid[i] && (fifo_entries[i].wmask != '0) &&
          (word_of(fifo_entries[i].addr) == ld_word))
        ld_conflict = 1'b1;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fifo_entries, fifo_valid};
`endif

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed self-checking bench for mem_store_buffer (STORE_FWD_EN checks when defined).
module tb_mem_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;
  logic [2:0]  count;
  logic        drained;
`ifdef STORE_FWD_EN
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_conflict;
`endif

  int passed = 0;
  int total  = 0;

  mem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_addr         (st_addr),
    .st_wdata        (st_wdata),
    .st_wmask        (st_wmask),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
`ifdef STORE_FWD_EN
    .ld_valid        (ld_valid),
    .ld_addr         (ld_addr),
    .ld_conflict     (ld_conflict),
`endif
    .count           (count),
    .drained         (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_wmask = m;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    int cyc;
    cyc = 0;
    mem_resp = 1'b1;
    while (!drained && cyc < 50) begin
      tick();
      cyc++;
    end
    mem_resp = 1'b0;
    total++;
    if (drained !== 1'b1) $display("FAIL drain_timeout: drained=%b count=%0d required drained=1", drained, count);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++;
    if ({mem_write, st_ready, drained, count} !== {1'b0, 1'b1, 1'b1, 3'd0})
      $display("FAIL reset_flags: wr=%b rdy=%b drn=%b cnt=%0d required 0 1 1 0", mem_write, st_ready, drained, count);
    else passed++;
    total++;
    if ({mem_address, mem_wdata, mem_byte_enable} !== 68'd0)
      $display("FAIL reset_port: addr=%h data=%h be=%b required zeros", mem_address, mem_wdata, mem_byte_enable);
    else passed++;
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    push(32'h0000_1006, 32'h00AB_0000, 4'b0100);
    total++;
    if ({mem_write, count} !== {1'b0, 3'd1})
      $display("FAIL single_accept: wr=%b cnt=%0d required 0 1", mem_write, count);
    else passed++;
    tick();
    total++;
    if ({mem_write, mem_address, mem_wdata, mem_byte_enable} !== {1'b1, 32'h0000_1004, 32'h00AB_0000, 4'b0100})
      $display("FAIL single_issue: wr=%b addr=%h data=%h be=%b required 1 00001004 00ab0000 0100",
               mem_write, mem_address, mem_wdata, mem_byte_enable);
    else passed++;
    tick();
    tick();
    total++;
    if ({mem_write, mem_address} !== {1'b1, 32'h0000_1004})
      $display("FAIL single_hold: wr=%b addr=%h required 1 00001004", mem_write, mem_address);
    else passed++;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    total++;
    if ({mem_write, count, drained} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL single_done: wr=%b cnt=%0d drn=%b required 0 0 1", mem_write, count, drained);
    else passed++;
  endtask

  task automatic test_full();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h0000_0100;
    exp_addr[1] = 32'h0000_0204;
    exp_addr[2] = 32'h0000_0308;
    exp_addr[3] = 32'h0000_040C;
    for (int i = 0; i < 4; i++) push(exp_addr[i] | 32'd1, 32'h1111_0000 + i, 4'b1111);
    total++;
    if ({st_ready, count} !== {1'b0, 3'd4})
      $display("FAIL full_flags: rdy=%b cnt=%0d required 0 4", st_ready, count);
    else passed++;
    push(32'h0000_0500, 32'hDEAD_BEEF, 4'b1111);
    total++;
    if (count !== 3'd4) $display("FAIL full_reject: cnt=%0d required 4", count);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({mem_write, mem_address} !== {1'b1, exp_addr[k]})
        $display("FAIL full_order%0d: wr=%b addr=%h required 1 %h", k, mem_write, mem_address, exp_addr[k]);
      else passed++;
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
      if (k == 0) begin
        total++;
        if ({st_ready, count, mem_write} !== {1'b1, 3'd3, 1'b0})
          $display("FAIL full_free: rdy=%b cnt=%0d wr=%b required 1 3 0", st_ready, count, mem_write);
        else passed++;
      end
      if (k < 3) tick();
    end
    total++;
    if ({drained, count} !== {1'b1, 3'd0})
      $display("FAIL full_empty: drn=%b cnt=%0d required 1 0", drained, count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    push(32'h0000_0600, 32'hAAAA_0000, 4'b1111);
    push(32'h0000_0704, 32'hBBBB_0000, 4'b1111);
    total++;
    if ({count, mem_write, mem_address} !== {3'd2, 1'b1, 32'h0000_0600})
      $display("FAIL b2b_setup: cnt=%0d wr=%b addr=%h required 2 1 00000600", count, mem_write, mem_address);
    else passed++;
    mem_resp = 1'b1;
    push(32'h0000_0808, 32'hCCCC_0000, 4'b1111);
    mem_resp = 1'b0;
    total++;
    if ({count, mem_write} !== {3'd2, 1'b0})
      $display("FAIL b2b_count: cnt=%0d wr=%b required 2 0", count, mem_write);
    else passed++;
    tick();
    total++;
    if ({mem_write, mem_address, mem_wdata} !== {1'b1, 32'h0000_0704, 32'hBBBB_0000})
      $display("FAIL b2b_next: wr=%b addr=%h data=%h required 1 00000704 bbbb0000", mem_write, mem_address, mem_wdata);
    else passed++;
    drain_all();
  endtask

  task automatic test_zero_mask();
    int writes;
    logic [31:0] last_addr;
    writes    = 0;
    last_addr = '0;
    push(32'h0000_0900, 32'h0, 4'b0000);
    push(32'h0000_0A00, 32'h5555_5555, 4'b1111);
    for (int c = 0; c < 12; c++) begin
      mem_resp = mem_write;
      if (mem_write) begin
        writes++;
        last_addr = mem_address;
      end
      tick();
    end
    mem_resp = 1'b0;
    total++;
    if ({writes, last_addr} !== {32'd1, 32'h0000_0A00})
      $display("FAIL zero_mask: writes=%0d addr=%h required 1 00000a00", writes, last_addr);
    else passed++;
    total++;
    if (drained !== 1'b1) $display("FAIL zero_mask_drained: drn=%b required 1", drained);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    push(32'h0000_0B00, 32'h1, 4'b1111);
    push(32'h0000_0C00, 32'h2, 4'b1111);
    push(32'h0000_0D00, 32'h3, 4'b1111);
    total++;
    if ({mem_write, count} !== {1'b1, 3'd3})
      $display("FAIL rst_mid_setup: wr=%b cnt=%0d required 1 3", mem_write, count);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({mem_write, count, st_ready, drained} !== {1'b0, 3'd0, 1'b1, 1'b1})
      $display("FAIL rst_mid_async: wr=%b cnt=%0d rdy=%b drn=%b required 0 0 1 1", mem_write, count, st_ready, drained);
    else passed++;
    #2 rst = 1'b1;
    mem_resp = 1'b1;
    tick();
    tick();
    mem_resp = 1'b0;
    total++;
    if ({mem_write, count, drained} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL rst_mid_resp: wr=%b cnt=%0d drn=%b required 0 0 1", mem_write, count, drained);
    else passed++;
  endtask

`ifdef STORE_FWD_EN
  task automatic test_fwd();
    push(32'h0000_2008, 32'h0000_1234, 4'b0011);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_200A;
    #1;
    total++;
    if (ld_conflict !== 1'b1) $display("FAIL fwd_hit: conflict=%b required 1", ld_conflict);
    else passed++;
    ld_addr = 32'h0000_200C;
    #1;
    total++;
    if (ld_conflict !== 1'b0) $display("FAIL fwd_miss: conflict=%b required 0", ld_conflict);
    else passed++;
    ld_addr  = 32'h0000_2008;
    ld_valid = 1'b0;
    #1;
    total++;
    if (ld_conflict !== 1'b0) $display("FAIL fwd_novalid: conflict=%b required 0", ld_conflict);
    else passed++;
    drain_all();
    ld_valid = 1'b1;
    #1;
    total++;
    if (ld_conflict !== 1'b0) $display("FAIL fwd_drained: conflict=%b required 0", ld_conflict);
    else passed++;
    ld_valid = 1'b0;
  endtask
`endif

  initial begin
    st_valid = 1'b0;
    st_addr  = '0;
    st_wdata = '0;
    st_wmask = '0;
    mem_resp = 1'b0;
`ifdef STORE_FWD_EN
    ld_valid = 1'b0;
    ld_addr  = '0;
`endif
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_zero_mask();
    test_reset_mid_write();
`ifdef STORE_FWD_EN
    test_fwd();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
